adc_lane_serializer: RTL and testbench

Transmit-side counterpart of the ADC front-end lane capture path. Accepts parallel sample words over a valid/ready handshake and drives them out as per-lane DDR bit pairs (`bit_rise`/`bit_fall`) on `dco_clk`, with a frame marker. It serves as the ADC emulator/loopback source for the front end, and as the transmitter when the design drives an LVDS link. A training-pattern mode supports lane alignment at the receiver.

---
 rtl/adc_fe_pkg.sv | 21 ++
 rtl/word_fifo2.sv | 58 +++++
 rtl/adc_lane_serializer.sv | 205 ++++++++++++++++++++
 tb/tb_adc_lane_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg
// Items shared by the ADC front-end serializer files.
//   ser_state_e        : serializer FSM states (IDLE, SEND, TRAIN)
//   TRAIN_WORD_DEFAULT : default word repeated during lane training
//   slices_per_word()  : DDR slice cycles needed to send one sample word
package adc_fe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TRAIN = 2'd2
    } ser_state_e;

    localparam logic [31:0] TRAIN_WORD_DEFAULT = 32'hA5A5_0FF0;

    // Each slice cycle moves 2 bits per lane (one per DDR half-cycle).
    function automatic int slices_per_word(input int lanes, input int sample_w);
        return sample_w / (2 * lanes);
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// word_fifo2
// Two-entry synchronous FIFO with first-word-fall-through read data.
// A push and a pop in the same cycle are both honoured, including when the
// FIFO is full (the pop frees the slot the push fills).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (ignored when full without a pop)
//   pop        : read strobe (ignored when empty)
//   dout       : head entry, valid while !empty
//   full/empty : occupancy flags from the registered count
module word_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_lane_serializer.sv
// adc_lane_serializer
// Sends parallel sample words out as per-lane DDR bit pairs on dco_clk.
// A word is cut into CYC = SAMPLE_W/(2*LANES) slices, lowest slice first;
// lane i carries slice bit 2i on bit_rise[i] and bit 2i+1 on bit_fall[i].
// train_req substitutes TRAIN_WORD at word boundaries without touching the
// queued data.
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready depends only on registered state (FIFO count, reset flag), never
// on s_valid; once s_valid is raised the word must be held until accepted.
//
// Optional feature macro: ADC_SER_UNDERRUN_CNT_EN
//   defined   -> 8-bit saturating underrun counter on underrun_cnt
//   undefined -> underrun_cnt tied to 0
//
// Ports:
//   dco_clk, rst_n     : clock, asynchronous active-low reset
//   s_word/s_valid     : input sample word and its valid
//   s_ready            : FIFO can take a word (0 while in reset)
//   train_req          : send TRAIN_WORD from the next word boundary on
//   bit_rise/bit_fall  : registered DDR bit pairs, one per lane
//   frame              : high on slice 0 of every transmitted word
//   tx_active          : a data or training word is on the outputs
//   underrun_cnt       : SEND -> IDLE boundaries caused by an empty FIFO
//   dbg_state          : current FSM state for observation
module adc_lane_serializer
    import adc_fe_pkg::*;
#(
    parameter int                    LANES      = 8,
    parameter int                    SAMPLE_W   = 32,
    parameter logic [SAMPLE_W-1:0]   TRAIN_WORD = SAMPLE_W'(TRAIN_WORD_DEFAULT)
) (
    input  logic                dco_clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] s_word,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                train_req,
    output logic [LANES-1:0]    bit_rise,
    output logic [LANES-1:0]    bit_fall,
    output logic                frame,
    output logic                tx_active,
    output logic [7:0]          underrun_cnt,
    output ser_state_e          dbg_state
);

    localparam int SLICE_W = 2 * LANES;
    localparam int CYC     = slices_per_word(LANES, SAMPLE_W);
    localparam int CNT_W   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYC - 1);

    ser_state_e          state;
    ser_state_e          state_next;
    logic [CNT_W-1:0]    slice_cnt;
    logic [CNT_W-1:0]    slice_cnt_d;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] shreg_d;
    logic [SAMPLE_W-1:0] word_src;
    logic [SLICE_W-1:0]  slice_d;
    logic [LANES-1:0]    rise_d;
    logic [LANES-1:0]    fall_d;
    logic                frame_d;
    logic                tx_active_d;
    logic                decision;
    logic                fifo_pop;
    logic                fifo_push;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ready_q;

    // ---------------------------------------------------------------
    // Input buffering
    // ---------------------------------------------------------------
    // ready_q keeps s_ready low during reset and rises at the first edge
    // after release.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign s_ready   = ready_q && !fifo_full;
    assign fifo_push = s_valid && s_ready;

    word_fifo2 #(
        .W (SAMPLE_W)
    ) u_fifo (
        .clk   (dco_clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (s_word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    // A new word may start every cycle in IDLE, otherwise only when the
    // last slice of the current word is on the outputs.
    assign decision  = (state == IDLE) || (slice_cnt == LAST_CNT);
    assign dbg_state = state;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        if (decision) begin
            if (train_req) begin
                state_next = TRAIN;
            end else if (!fifo_empty) begin
                state_next = SEND;
                fifo_pop   = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Next values for the registered outputs and the slice shifter. On a
    // decision edge slice 0 of the chosen word goes straight out, and the
    // remaining slices are parked in shreg.
    always_comb begin
        word_src    = '0;
        slice_d     = '0;
        shreg_d     = '0;
        slice_cnt_d = '0;
        frame_d     = 1'b0;
        tx_active_d = 1'b0;
        if (decision) begin
            if (state_next != IDLE) begin
                word_src    = (state_next == TRAIN) ? TRAIN_WORD : fifo_dout;
                slice_d     = word_src[SLICE_W-1:0];
                shreg_d     = word_src >> SLICE_W;
                frame_d     = 1'b1;
                tx_active_d = 1'b1;
            end
        end else begin
            slice_d     = shreg[SLICE_W-1:0];
            shreg_d     = shreg >> SLICE_W;
            slice_cnt_d = slice_cnt + CNT_W'(1);
            tx_active_d = 1'b1;
        end
    end

    // Lane mapping: even slice bits on the rising half, odd on the falling.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < LANES; i++) begin
            rise_d[i] = slice_d[2*i];
            fall_d[i] = slice_d[2*i+1];
        end
    end

    // Datapath registers. Reset clears the shifter too, so a word cut by
    // reset leaves nothing behind.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_rise  <= '0;
            bit_fall  <= '0;
            frame     <= 1'b0;
            tx_active <= 1'b0;
            shreg     <= '0;
            slice_cnt <= '0;
        end else begin
            bit_rise  <= rise_d;
            bit_fall  <= fall_d;
            frame     <= frame_d;
            tx_active <= tx_active_d;
            shreg     <= shreg_d;
            slice_cnt <= slice_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Underrun counter
    // ---------------------------------------------------------------
`ifdef ADC_SER_UNDERRUN_CNT_EN
    logic       underrun_evt;
    logic [7:0] underrun_q;

    // Only a data stream running dry counts; leaving TRAIN does not.
    assign underrun_evt = decision && (state == SEND) && (state_next == IDLE);

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 8'd0;
        end else if (underrun_evt && (underrun_q != 8'hFF)) begin
            underrun_q <= underrun_q + 8'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_adc_lane_serializer.sv
module tb_adc_lane_serializer;
    import adc_fe_pkg::*;

    localparam int LANES    = 8;
    localparam int SAMPLE_W = 32;
    localparam int SLICE_W  = 16;
    localparam int CYC      = 2;
    localparam logic [31:0] TW = 32'hA5A5_0FF0;

`ifdef ADC_SER_UNDERRUN_CNT_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic                dco_clk = 1'b0;
    logic                rst_n   = 1'b0;
    logic [SAMPLE_W-1:0] s_word  = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                train_req = 1'b0;
    logic [LANES-1:0]    bit_rise;
    logic [LANES-1:0]    bit_fall;
    logic                frame;
    logic                tx_active;
    logic [7:0]          underrun_cnt;
    ser_state_e          dbg_state;

    always #5 dco_clk = ~dco_clk;

    adc_lane_serializer dut (
        .dco_clk      (dco_clk),
        .rst_n        (rst_n),
        .s_word       (s_word),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .train_req    (train_req),
        .bit_rise     (bit_rise),
        .bit_fall     (bit_fall),
        .frame        (frame),
        .tx_active    (tx_active),
        .underrun_cnt (underrun_cnt),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [SAMPLE_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called right after a negedge; returns at the negedge after acceptance.
    task automatic send_word(input logic [SAMPLE_W-1:0] w, input bit push_exp);
        bit done;
        done    = 1'b0;
        s_word  = w;
        s_valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            if (s_ready) begin
                if (push_exp) exp_q.push_back(w);
                done = 1'b1;
            end
            @(negedge dco_clk);
        end
        s_valid = 1'b0;
        check("send_accepted", done, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge dco_clk);
            idle = !tx_active && (exp_q.size() == 0);
        end
        check("drain_idle", idle, 1'b1);
    endtask

    // ---------------- scoreboard monitor ----------------
    int                  mon_idx = 0;
    logic [SAMPLE_W-1:0] mon_acc = '0;

    always @(negedge dco_clk) begin
        if (!rst_n) begin
            mon_idx = 0;
        end else if (tx_active) begin
            check("frame_pos", frame, (mon_idx == 0));
            if (frame) mon_idx = 0;
            for (int i = 0; i < LANES; i++) begin
                mon_acc[mon_idx*SLICE_W + 2*i]     = bit_rise[i];
                mon_acc[mon_idx*SLICE_W + 2*i + 1] = bit_fall[i];
            end
            mon_idx++;
            if (mon_idx == CYC) begin
                mon_idx = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h expected none (t=%0t)", mon_acc, $time);
                end else begin
                    check("word", mon_acc, exp_q.pop_front());
                end
            end
        end else begin
            check("idle_zero", {frame, bit_rise, bit_fall}, '0);
            check("word_truncated", mon_idx, 0);
            mon_idx = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Test 1: reset and quiet idle
        repeat (3) @(negedge dco_clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_outputs", {frame, bit_rise, bit_fall}, '0);
        check("rst_underrun", underrun_cnt, 8'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        #1;
        check("release_s_ready_pre_edge", s_ready, 1'b0);
        @(negedge dco_clk);
        for (int k = 0; k < 10; k++) begin
            check("idle_s_ready", s_ready, 1'b1);
            check("idle_tx_active", tx_active, 1'b0);
            @(negedge dco_clk);
        end

        // Test 2: single word, directed lane values
        send_word(32'h1234_5678, 1'b1);
        @(negedge dco_clk);
        check("t2_rise0", bit_rise, 8'hEC);
        check("t2_fall0", bit_fall, 8'h16);
        check("t2_frame0", frame, 1'b1);
        check("t2_active0", tx_active, 1'b1);
        @(negedge dco_clk);
        check("t2_rise1", bit_rise, 8'h46);
        check("t2_fall1", bit_fall, 8'h14);
        check("t2_frame1", frame, 1'b0);
        @(negedge dco_clk);
        check("t2_idle", tx_active, 1'b0);
        check("t2_underrun", underrun_cnt, UR_EN ? 8'd1 : 8'd0);
        wait_idle();

        // Test 3: 20 back-to-back words, continuous stream
        fork
            begin
                for (int n = 0; n < 20; n++) send_word($urandom, 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge dco_clk);
                    seen = tx_active;
                end
                check("t3_start", seen, 1'b1);
                for (int k = 0; k < 40; k++) begin
                    check("t3_continuous", tx_active, 1'b1);
                    check("t3_frame_cadence", frame, (k % 2 == 0));
                    @(negedge dco_clk);
                end
            end
        join
        wait_idle();
        check("t3_underrun", underrun_cnt, UR_EN ? 8'd2 : 8'd0);

        // Test 4: training requested mid-word with data queued behind
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(TW);
        exp_q.push_back(TW);
        exp_q.push_back(32'hCAFE_0002);
        exp_q.push_back(32'hCAFE_0003);
        send_word(32'hCAFE_0001, 1'b0);      // accepted at E
        send_word(32'hCAFE_0002, 1'b0);      // accepted at E+1, slice 0 of A out
        train_req = 1'b1;
        send_word(32'hCAFE_0003, 1'b0);      // accepted at E+2
        @(negedge dco_clk);                  // after E+3: training word 1
        check("t4_train_frame", frame, 1'b1);
        check("t4_state_train", 64'(dbg_state), 64'(TRAIN));
        check("t4_fifo_full", s_ready, 1'b0);
        repeat (2) @(negedge dco_clk);       // after E+5: training word 2
        train_req = 1'b0;
        check("t4_no_underrun", underrun_cnt, UR_EN ? 8'd2 : 8'd0);
        wait_idle();
        check("t4_underrun_end", underrun_cnt, UR_EN ? 8'd3 : 8'd0);

        // Test 5: reset during slice 1 with two words queued
        send_word(32'h1111_1111, 1'b0);      // accepted at E
        send_word(32'h2222_2222, 1'b0);      // accepted at E+1
        check("t5_ready_before_c", s_ready, 1'b1);
        s_word  = 32'h3333_3333;
        s_valid = 1'b1;
        @(posedge dco_clk);                  // E+2: C pushed, slice 1 of A out
        #2;
        s_valid = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_outputs", {frame, bit_rise, bit_fall}, '0);
        check("t5_rst_active", tx_active, 1'b0);
        check("t5_rst_ready", s_ready, 1'b0);
        repeat (2) @(negedge dco_clk);
        rst_n = 1'b1;
        @(negedge dco_clk);
        check("t5_underrun_cleared", underrun_cnt, 8'd0);
        for (int k = 0; k < 10; k++) begin
            check("t5_no_replay", tx_active, 1'b0);
            check("t5_fifo_empty_ready", s_ready, 1'b1);
            @(negedge dco_clk);
        end

`ifdef ADC_SER_UNDERRUN_CNT_EN
        // Test 6: underrun counter saturation
        for (int n = 0; n < 300; n++) begin
            send_word(32'h0F0F_0000 + n, 1'b1);
            wait_idle();
            if (n == 253) check("t6_cnt_254", underrun_cnt, 8'd254);
            if (n == 254) check("t6_cnt_255", underrun_cnt, 8'd255);
        end
        check("t6_saturated", underrun_cnt, 8'd255);
`endif

        wait_idle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
